// File: rtl/pcpu_bus_pkg.sv
// pcpu_bus_pkg: arbiter state encoding, bus error data and master index constants.
package pcpu_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;
  localparam logic M_DATA = 1'b0;
  localparam logic M_FETCH = 1'b1;
endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: WAIT-cycle counter; expired flags the TIMEOUT-th WAIT cycle.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 1023,
  parameter int TIMEOUT_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [TIMEOUT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst_n || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_expired = r_cnt == TIMEOUT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter (m0 data, m1 fetch) in front of the address mapper.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import pcpu_bus_pkg::*;
#(
  parameter bit FIRST_PRI = 1'b0
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
  , parameter int TIMEOUT_W = 10
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_m0_a,
  input  logic [31:0] i_m0_d,
  input  logic        i_m0_we,
  input  logic        i_m0_rd,
  output logic [31:0] o_m0_spo,
  output logic        o_m0_ready,
  output logic        o_m0_err,
  input  logic [31:0] i_m1_a,
  input  logic        i_m1_rd,
  output logic [31:0] o_m1_spo,
  output logic        o_m1_ready,
  output logic        o_m1_err,
  output logic [31:0] o_s_a,
  output logic [31:0] o_s_d,
  output logic        o_s_we,
  output logic        o_s_rd,
  input  logic [31:0] i_s_spo,
  input  logic        i_s_ready,
  input  logic        i_s_irq
);
  arb_state_e  r_state, w_next;
  logic        r_grant, r_last, r_we, r_rd, r_irq;
  logic [31:0] r_a, r_d;
  logic        w_req0, w_req1, w_pick, w_expired, w_tmo, w_done, w_err;
  logic [31:0] w_spo;
`ifdef ARB_TIMEOUT_EN
  arb_timeout_ctr #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) u_tmo (
    .clk(clk), .rst_n(rst_n), .i_clr(r_state == ISSUE), .i_en(r_state == WAIT), .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  assign w_req0 = i_m0_we | i_m0_rd;
  assign w_req1 = i_m1_rd;
  assign w_pick = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_tmo  = w_expired & ~i_s_ready;
  assign w_done = (r_state == WAIT) & (i_s_ready | w_tmo);
  assign w_err  = r_irq | i_s_irq | w_tmo;
  // an error always returns zero data unless it is a timeout, which returns the error pattern
  assign w_spo  = w_tmo ? BUS_ERR_DATA : (r_irq | i_s_irq | r_we) ? 32'h0 : i_s_spo;
  assign o_s_a  = (r_state == IDLE) ? 32'h0 : r_a;
  assign o_s_d  = (r_state == IDLE) ? 32'h0 : r_d;
  assign o_s_we = (r_state == ISSUE) & r_we;
  assign o_s_rd = (r_state == ISSUE) & r_rd & ~r_we;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? ((w_req0 | w_req1) ? ISSUE : IDLE) :
             (r_state == ISSUE) ? WAIT : (w_done ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= M_DATA;
      r_last <= ~FIRST_PRI;
      r_a <= '0;
      r_d <= '0;
      r_we <= 1'b0;
      r_rd <= 1'b0;
      r_irq <= 1'b0;
      o_m0_spo <= '0;
      o_m0_err <= 1'b0;
      o_m0_ready <= 1'b0;
      o_m1_spo <= '0;
      o_m1_err <= 1'b0;
      o_m1_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      o_m0_ready <= 1'b0;
      o_m1_ready <= 1'b0;
      if (r_state == IDLE && (w_req0 | w_req1)) begin
        r_grant <= w_pick;
        r_a <= w_pick ? i_m1_a : i_m0_a;
        r_d <= w_pick ? 32'h0 : i_m0_d;
        r_we <= ~w_pick & i_m0_we;
        r_rd <= w_pick | i_m0_rd;
        r_irq <= 1'b0;
      end else if (r_state != IDLE && i_s_irq) r_irq <= 1'b1;
      if (w_done) begin
        r_last <= r_grant;
        if (r_grant == M_FETCH) begin
          o_m1_ready <= 1'b1;
          o_m1_err <= w_err;
          o_m1_spo <= w_spo;
        end else begin
          o_m0_ready <= 1'b1;
          o_m0_err <= w_err;
          o_m0_spo <= w_spo;
        end
      end
    end
  end
endmodule
